// File: rtl/display_pkg.sv
// Shared types and default geometry for the display frame sequencer.
// Imported by the interface, the row buffer and the top-level sequencer.
package display_pkg;

    localparam int WIDTH_DEF       = 120;
    localparam int HEIGHT_DEF      = 52;
    localparam int RNDSIZE_DEF     = 9;
    localparam int NB_SEGMENTS_DEF = 7;
    localparam int DP_LATENCY_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STREAM  = 3'd4
    } seq_state_e;

    // Row index width; a single-row display still needs one bit.
    function automatic int idx_width(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/display_frame_seq_if.sv
// Config / random / datapath / row-stream bundle of the frame sequencer.
// cfg_watmk exists only when DISPLAY_SEQ_WATERMARK_EN is defined.
interface display_frame_seq_if
    import display_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int RNDSIZE     = RNDSIZE_DEF,
    parameter int NB_SEGMENTS = NB_SEGMENTS_DEF
);
    localparam int IDX_W = idx_width(HEIGHT);

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic                      cfg_z;
    logic [NB_SEGMENTS-1:0]    cfg_msg;
`ifdef DISPLAY_SEQ_WATERMARK_EN
    logic [WIDTH*HEIGHT-1:0]   cfg_watmk;
`endif
    logic                      rnd_valid;
    logic                      rnd_ready;
    logic [RNDSIZE-1:0]        rnd_data;
    logic                      dp_z;
    logic [NB_SEGMENTS-1:0]    dp_msg;
    logic [RNDSIZE-1:0]        dp_rnd;
    logic [WIDTH*HEIGHT-1:0]   dp_watmk;
    logic [WIDTH*HEIGHT-1:0]   dp_pix;
    logic                      row_valid;
    logic                      row_ready;
    logic [WIDTH-1:0]          row_data;
    logic [IDX_W-1:0]          row_idx;
    logic                      row_last;

    modport slave (
`ifdef DISPLAY_SEQ_WATERMARK_EN
        input  cfg_watmk,
`endif
        input  cfg_valid, cfg_z, cfg_msg, rnd_valid, rnd_data, dp_pix, row_ready,
        output cfg_ready, rnd_ready, dp_z, dp_msg, dp_rnd, dp_watmk,
        output row_valid, row_data, row_idx, row_last
    );

    modport master (
`ifdef DISPLAY_SEQ_WATERMARK_EN
        output cfg_watmk,
`endif
        output cfg_valid, cfg_z, cfg_msg, rnd_valid, rnd_data, dp_pix, row_ready,
        input  cfg_ready, rnd_ready, dp_z, dp_msg, dp_rnd, dp_watmk,
        input  row_valid, row_data, row_idx, row_last
    );

endinterface

// File: rtl/display_row_buf.sv
// Frame buffer plus row mux: loads a whole frame, then streams it row by row.
// Row outputs are registered; the first row appears one cycle after the load.
module display_row_buf
    import display_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int HEIGHT = HEIGHT_DEF,
    localparam int IDX_W  = idx_width(HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [WIDTH*HEIGHT-1:0] i_pix,
    input  logic                    i_advance,
    output logic                    o_row_valid,
    output logic [WIDTH-1:0]        o_row_data,
    output logic [IDX_W-1:0]        o_row_idx,
    output logic                    o_row_last
);
    logic [WIDTH*HEIGHT-1:0] r_frame;
    logic                    r_pending;
    logic                    r_valid;
    logic [WIDTH-1:0]        r_data;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_last;
    logic [IDX_W-1:0]        w_next_idx;

    assign w_next_idx  = r_idx + IDX_W'(1);
    assign o_row_valid = r_valid;
    assign o_row_data  = r_data;
    assign o_row_idx   = r_idx;
    assign o_row_last  = r_last;

    // Frame capture, first-row presentation and per-beat row advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame   <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
        end else if (i_load) begin
            r_frame   <= i_pix;
            r_pending <= 1'b1;
        end else if (r_pending) begin
            r_pending <= 1'b0;
            r_valid   <= 1'b1;
            r_data    <= r_frame[WIDTH-1:0];
            r_idx     <= '0;
            r_last    <= (HEIGHT == 1);
        end else if (i_advance) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_data <= r_frame[w_next_idx*WIDTH +: WIDTH];
                r_idx  <= w_next_idx;
                r_last <= (w_next_idx == IDX_W'(HEIGHT - 1));
            end
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: rtl/display_frame_seq.sv
// Garbled-display frame sequencer: config, random, datapath settle, capture, row stream.
// Optional watermark path enabled by DISPLAY_SEQ_WATERMARK_EN.
module display_frame_seq
    import display_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int RNDSIZE     = RNDSIZE_DEF,
    parameter int NB_SEGMENTS = NB_SEGMENTS_DEF,
    parameter int DP_LATENCY  = DP_LATENCY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    display_frame_seq_if.slave  bus,
    output logic                busy,
    output logic [15:0]         frame_cnt
);
    localparam int IDX_W = idx_width(HEIGHT);

    seq_state_e             r_state;
    logic [3:0]             r_settle_cnt;
    logic                   r_cfg_ready;
    logic                   r_rnd_ok;
    logic                   r_busy;
    logic [15:0]            r_frame_cnt;
    logic                   r_dp_z;
    logic [NB_SEGMENTS-1:0] r_dp_msg;
    logic [RNDSIZE-1:0]     r_dp_rnd;

    logic                   w_cfg_xfer;
    logic                   w_rnd_xfer;
    logic                   w_beat;
    logic                   w_load;
    logic                   w_row_valid;
    logic [WIDTH-1:0]       w_row_data;
    logic [IDX_W-1:0]       w_row_idx;
    logic                   w_row_last;

    // cfg_ready is forced low while reset is held; config wins over random.
    assign bus.cfg_ready = r_cfg_ready & ~rst;
    assign bus.rnd_ready = r_rnd_ok & ~bus.cfg_valid;
    assign w_cfg_xfer    = bus.cfg_valid & bus.cfg_ready;
    assign w_rnd_xfer    = bus.rnd_valid & bus.rnd_ready;
    assign w_beat        = w_row_valid & bus.row_ready;
    assign w_load        = (r_state == ST_CAPTURE);

    assign bus.dp_z      = r_dp_z;
    assign bus.dp_msg    = r_dp_msg;
    assign bus.dp_rnd    = r_dp_rnd;
    assign bus.row_valid = w_row_valid;
    assign bus.row_data  = w_row_data;
    assign bus.row_idx   = w_row_idx;
    assign bus.row_last  = w_row_last;
    assign busy          = r_busy;
    assign frame_cnt     = r_frame_cnt;

`ifdef DISPLAY_SEQ_WATERMARK_EN
    logic [WIDTH*HEIGHT-1:0] r_dp_watmk;
    assign bus.dp_watmk = r_dp_watmk;

    // Watermark follows the config transfer and is held like the other dp_* values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_watmk <= '0;
        end else if (w_cfg_xfer) begin
            r_dp_watmk <= bus.cfg_watmk;
        end else begin
            r_dp_watmk <= r_dp_watmk;
        end
    end
`else
    assign bus.dp_watmk = '0;
`endif

    // Sequencer FSM; handshake readiness and busy are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_cfg_ready  <= 1'b1;
            r_rnd_ok     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_dp_z       <= 1'b0;
            r_dp_msg     <= '0;
            r_dp_rnd     <= '0;
        end else begin
            if (w_cfg_xfer) begin
                r_dp_z   <= bus.cfg_z;
                r_dp_msg <= bus.cfg_msg;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_xfer) begin
                        r_state  <= ST_READY;
                        r_rnd_ok <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_rnd_xfer) begin
                        r_dp_rnd    <= bus.rnd_data;
                        r_cfg_ready <= 1'b0;
                        r_rnd_ok    <= 1'b0;
                        r_busy      <= 1'b1;
                        if (DP_LATENCY == 0) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= 4'(DP_LATENCY - 1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_beat && w_row_last) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= ST_READY;
                        r_cfg_ready <= 1'b1;
                        r_rnd_ok    <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cfg_ready <= 1'b1;
                    r_rnd_ok    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    display_row_buf #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_row_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_pix       (bus.dp_pix),
        .i_advance   (w_beat),
        .o_row_valid (w_row_valid),
        .o_row_data  (w_row_data),
        .o_row_idx   (w_row_idx),
        .o_row_last  (w_row_last)
    );

endmodule
